mux2_reg: RTL and testbench
===========================

Name: mux2_reg

Overview:
- Registered 2:1 selector for W-bit operands; the output is widened by one bit to carry a source tag.
- Used as the operand/result steering element in the datapath, ahead of the adder/ALU stages.
- Single clock domain; all outputs change only on the rising edge of clk.

Parameters:
- W, 8, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- A_in  input  W  operand A, selected when sel_in = 0
- B_in  input  W  operand B, selected when sel_in = 1
- sel_in  input  1  select; 0 selects A_in, 1 selects B_in
- Out_out  output  W+1  registered result; [W-1:0] = selected data, [W] = source tag (0 = A, 1 = B)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- On each rising clk edge with reset = 1: Out_out <= 0 (all W+1 bits), regardless of sel_in, A_in or B_in.
- On each rising clk edge with reset = 0:
  - Out_out[W-1:0] <= sel_in ? B_in : A_in
  - Out_out[W] <= sel_in
- Latency: exactly one cycle from input sampling to output. Inputs are sampled only at the rising edge; input changes between edges have no effect on Out_out.
- No enable and no hold: the register loads every non-reset cycle.
- Width rule: the data field is copied bit-exact with no extension or arithmetic. The tag bit is never derived from the data.
- Reset mid-stream: reset asserted in any cycle clears Out_out at that edge. The first edge after reset deasserts loads the current inputs normally.
- Simultaneous input and select changes at one edge: the values present at that edge are used as a coherent set.
- Before the first clock edge, Out_out is undefined. Benches must apply reset or ignore the output until the first loaded edge.
- Power-up: Out_out has no initial value in RTL; reset defines it.

Optional Feature:
- Macro: MUX2_REG_SWCNT_EN
- Defined:
  - Adds output port sw_cnt_out, 16 bits: a count of select switches.
  - Increments by 1 on each non-reset rising edge where sel_in differs from the registered Out_out[W].
  - Wraps from 16'hFFFF to 16'h0000.
  - Cleared to 0 by reset.
  - The first load after reset compares against tag 0, so it counts only if sel_in = 1.
  - The counter does not alter Out_out timing or values.
- Not defined:
  - sw_cnt_out port and counter logic are absent.
  - Port list is exactly as listed above.

Test Plan:
- Reset: reset=1, A_in=8'hFF, B_in=8'hAA, sel_in=1 for one edge -> Out_out = 9'h000.
- Select A: reset=0, A_in=3, B_in=2, sel_in=0, drive on negedge -> after next posedge Out_out = 9'h003.
- Select B: A_in=3, B_in=2, sel_in=1 on next negedge -> after next posedge Out_out = 9'h102. Before that posedge, Out_out still 9'h003.
- Extremes and setup: A_in=8'h00, B_in=8'hFF; toggle sel_in 0,1,0 on successive negedges -> Out_out = 9'h000, 9'h1FF, 9'h000. Glitch inputs mid-cycle and confirm only edge values appear.
- Reset mid-stream: with Out_out = 9'h1FF, assert reset one cycle -> 9'h000; deassert with sel_in=0, A_in=8'h5A -> 9'h05A.
- With MUX2_REG_SWCNT_EN: after reset, drive sel_in sequence 1,1,0,1,0 on five edges -> sw_cnt_out = 4. Preload near 16'hFFFF via toggling (or force) -> wraps to 0. Reset -> 0.

Source files
------------

// File: rtl/mux2_reg.sv
// mux2_reg: registered 2:1 operand selector with a source-tag bit.
// Out_out[W-1:0] holds the selected operand and Out_out[W] holds the select
// (0 = A, 1 = B), one cycle after sampling.
// Optional feature macro: MUX2_REG_SWCNT_EN adds sw_cnt_out, a 16-bit wrapping
// count of select switches relative to the registered tag.
module mux2_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] A_in,
   input  logic [W-1:0] B_in,
   input  logic         sel_in,
   output logic [W:0]   Out_out
`ifdef MUX2_REG_SWCNT_EN
   ,
   output logic [15:0]  sw_cnt_out
`endif
);

   localparam int unsigned OUT_W = W + 1;

   logic [OUT_W-1:0] out_d;
   logic [OUT_W-1:0] out_q;

   // Next result: tag bit is the raw select, data field is a bit-exact copy
   always_comb begin
      out_d = '0;
      out_d[W]     = sel_in;
      out_d[W-1:0] = sel_in ? B_in : A_in;
   end

   // Result register, loads every non-reset cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign Out_out = out_q;

`ifdef MUX2_REG_SWCNT_EN
   localparam int unsigned CNT_W = 16;

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Count edges where the new select differs from the registered tag; wraps naturally
   always_comb begin
      cnt_d = cnt_q;
      if (sel_in != out_q[W]) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Switch counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sw_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// tb_mux2_reg: directed, table-driven bench for mux2_reg (W = 8).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge. Counter checks are built when MUX2_REG_SWCNT_EN is defined.
module tb_mux2_reg;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         sel_in;
   logic [W:0]   out_out;
`ifdef MUX2_REG_SWCNT_EN
   logic [15:0]  sw_cnt;
`endif

   int total;
   int bad;

   mux2_reg #(.W(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .A_in    (a_in),
      .B_in    (b_in),
      .sel_in  (sel_in),
      .Out_out (out_out)
`ifdef MUX2_REG_SWCNT_EN
      ,
      .sw_cnt_out (sw_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic [7:0] a;
      logic [7:0] b;
      logic       sel;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [7:0] a, input logic [7:0] b, input logic sel);
      @(negedge clk);
      reset  = rst;
      a_in   = a;
      b_in   = b;
      sel_in = sel;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      reset  = 1'b1;
      a_in   = '0;
      b_in   = '0;
      sel_in = 1'b0;

      vecs[0]  = '{"reset",      1'b1, 8'hFF, 8'hAA, 1'b1, 9'h000};
      vecs[1]  = '{"sel_a",      1'b0, 8'h03, 8'h02, 1'b0, 9'h003};
      vecs[2]  = '{"sel_b",      1'b0, 8'h03, 8'h02, 1'b1, 9'h102};
      vecs[3]  = '{"ext_a0",     1'b0, 8'h00, 8'hFF, 1'b0, 9'h000};
      vecs[4]  = '{"ext_b",      1'b0, 8'h00, 8'hFF, 1'b1, 9'h1FF};
      vecs[5]  = '{"ext_a1",     1'b0, 8'h00, 8'hFF, 1'b0, 9'h000};
      vecs[6]  = '{"ext_b2",     1'b0, 8'h00, 8'hFF, 1'b1, 9'h1FF};
      vecs[7]  = '{"mid_reset",  1'b1, 8'h00, 8'hFF, 1'b1, 9'h000};
      vecs[8]  = '{"post_reset", 1'b0, 8'h5A, 8'hFF, 1'b0, 9'h05A};
      vecs[9]  = '{"b_low",      1'b0, 8'h80, 8'h01, 1'b1, 9'h101};
      vecs[10] = '{"a_high",     1'b0, 8'h7F, 8'hC3, 1'b0, 9'h07F};

      // Table-driven vectors, one edge each
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel);
         @(posedge clk);
         #1;
         check(vecs[i].name, 16'(out_out), 16'(vecs[i].exp));
      end

      // Output must hold until the edge after new inputs appear
      drive(1'b0, 8'h03, 8'h02, 1'b0);
      @(posedge clk);
      #1;
      check("hold_pre_a", 16'(out_out), 16'h0003);
      drive(1'b0, 8'h03, 8'h02, 1'b1);
      #1;
      check("hold_before_edge", 16'(out_out), 16'h0003);
      @(posedge clk);
      #1;
      check("hold_after_edge", 16'(out_out), 16'h0102);

      // Mid-cycle glitch: only values present at the edge are loaded
      drive(1'b0, 8'h11, 8'h22, 1'b0);
      @(posedge clk);
      #1;
      check("glitch_base", 16'(out_out), 16'h0011);
      #1;
      a_in   = 8'h33;
      sel_in = 1'b1;
      #1;
      check("glitch_no_effect", 16'(out_out), 16'h0011);
      b_in   = 8'h44;
      sel_in = 1'b0;
      #1;
      a_in   = 8'h55;
      b_in   = 8'h22;
      sel_in = 1'b1;
      @(posedge clk);
      #1;
      check("glitch_edge_value", 16'(out_out), 16'h0122);

`ifdef MUX2_REG_SWCNT_EN
      // Switch counter: reset, then select pattern 1,1,0,1,0 gives 4 switches
      drive(1'b1, 8'h00, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      check("cnt_reset", sw_cnt, 16'h0000);
      check("cnt_reset_out", 16'(out_out), 16'h0000);
      drive(1'b0, 8'h01, 8'h02, 1'b1);
      drive(1'b0, 8'h01, 8'h02, 1'b1);
      drive(1'b0, 8'h01, 8'h02, 1'b0);
      drive(1'b0, 8'h01, 8'h02, 1'b1);
      drive(1'b0, 8'h01, 8'h02, 1'b0);
      @(posedge clk);
      #1;
      check("cnt_seq", sw_cnt, 16'd4);
      check("cnt_seq_out", 16'(out_out), 16'h0001);

      // Toggle every edge up to the top of the range, then one more to wrap
      for (int i = 0; i < 65531; i++) begin
         drive(1'b0, 8'h01, 8'h02, (i % 2) == 0);
      end
      @(posedge clk);
      #1;
      check("cnt_max", sw_cnt, 16'hFFFF);
      drive(1'b0, 8'h01, 8'h02, ~out_out[W]);
      @(posedge clk);
      #1;
      check("cnt_wrap", sw_cnt, 16'h0000);
      drive(1'b0, 8'h01, 8'h02, ~out_out[W]);
      @(posedge clk);
      #1;
      check("cnt_after_wrap", sw_cnt, 16'h0001);
      drive(1'b1, 8'h01, 8'h02, 1'b1);
      @(posedge clk);
      #1;
      check("cnt_reset_again", sw_cnt, 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
